// File: rtl/pll_tuner_pkg.sv
// ---------------------------------------------------------------------------
// pll_tuner_pkg
//
// Shared types and constants for the PLL loop-filter tuner.
//   pll_setting_t     one table entry: {icp[5:0], res[2:0], cap[1:0]}
//   tune_state_t      supervisor state encoding
//   SETTING_W         packed width of one table entry (11 bits)
//   DEFAULT_SETTINGS  four entries ordered from low to high loop bandwidth,
//                     entry 0 in the LSBs
// ---------------------------------------------------------------------------
package pll_tuner_pkg;

    localparam int SETTING_W = 11;

    typedef struct packed {
        logic [5:0] icp;
        logic [2:0] res;
        logic [1:0] cap;
    } pll_setting_t;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        CONFIRM   = 3'd2,
        LOCKED    = 3'd3,
        FAIL      = 3'd4
    } tune_state_t;

    // Bandwidth grows with charge-pump current and loop resistance, so the
    // table walks both upward while shrinking the filter capacitor.
    localparam logic [4*SETTING_W-1:0] DEFAULT_SETTINGS = {
        {6'd32, 3'd6, 2'd0},    // entry 3: highest bandwidth
        {6'd16, 3'd4, 2'd1},    // entry 2
        {6'd8,  3'd2, 2'd2},    // entry 1
        {6'd4,  3'd1, 2'd3}     // entry 0: lowest bandwidth
    };

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchronizer for a single asynchronous level (the raw PLL lock).
// Adds two clk cycles of latency. Both flops clear on reset so the tuner
// never sees a stale "locked" level right after rst_n releases.
//
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input level
//   q      out  synchronized level
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_dyn_tuner.sv
// ---------------------------------------------------------------------------
// pll_dyn_tuner
//
// Loop-filter tuning and lock supervisor for a dynamic-loop PLL. Runs on the
// PLL reference clock. Each attempt holds the PLL in reset while a new
// {icp, res, cap} entry is applied, then waits for a stable lock within a
// timeout. On timeout the next table entry is tried; after MAX_SWEEPS full
// passes without lock the block parks in FAIL until retune_req.
//
// Optional feature: define PLL_TUNER_STATS_EN to build the saturating
// lock_loss_cnt / retry_cnt statistics counters; otherwise both read 0.
//
// Ports:
//   clk            in   reference clock (same net as PLL clkin)
//   rst_n          in   asynchronous active-low reset
//   retune_req     in   1-cycle pulse, restart search from entry 0
//   pll_lock       in   raw PLL lock, asynchronous
//   pll_reset      out  PLL reset
//   pll_icpsel     out  charge-pump current select [5:0]
//   pll_lpfres     out  loop-filter resistor select [2:0]
//   pll_lpfcap     out  loop-filter capacitor select [1:0]
//   pll_ready      out  lock confirmed
//   tune_fail      out  all sweeps exhausted
//   setting_idx    out  active table entry
//   lock_loss_cnt  out  lock-loss events (stats build only)
//   retry_cnt      out  timeout advances (stats build only)
// ---------------------------------------------------------------------------
module pll_dyn_tuner
    import pll_tuner_pkg::*;
#(
    parameter int NUM_SETTINGS = 4,
    parameter logic [NUM_SETTINGS*SETTING_W-1:0] SETTINGS = DEFAULT_SETTINGS,
    parameter int RESET_CYCLES = 64,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_SWEEPS   = 2,
    localparam int IDX_W = (NUM_SETTINGS > 1) ? $clog2(NUM_SETTINGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retune_req,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [5:0]       pll_icpsel,
    output logic [2:0]       pll_lpfres,
    output logic [1:0]       pll_lpfcap,
    output logic             pll_ready,
    output logic             tune_fail,
    output logic [IDX_W-1:0] setting_idx,
    output logic [7:0]       lock_loss_cnt,
    output logic [7:0]       retry_cnt
);

    localparam int RC_W = $clog2(RESET_CYCLES) + 1;
    localparam int TO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int ST_W = $clog2(LOCK_STABLE) + 1;
    localparam int SW_W = $clog2(MAX_SWEEPS) + 1;

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // ------------------------------------------------------------------
    // Unpack the settings table
    // ------------------------------------------------------------------
    pll_setting_t setting_tbl [NUM_SETTINGS];

    generate
        for (genvar gi = 0; gi < NUM_SETTINGS; gi++) begin : g_tbl
            assign setting_tbl[gi] = SETTINGS[gi*SETTING_W +: SETTING_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tune_state_t      state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [SW_W-1:0]  sweep_reg;
    logic [RC_W-1:0]  rst_cnt_reg;
    logic [TO_W-1:0]  timeout_reg;
    logic [ST_W-1:0]  stable_reg;
    logic             reset_reg;
    pll_setting_t     setting_reg;
    logic             ready_reg;
    logic             fail_reg;

    // ------------------------------------------------------------------
    // Transition conditions
    // ------------------------------------------------------------------
    logic             in_search;
    logic             to_hit;
    logic             confirm_done;
    logic             timeout_evt;
    logic             lock_lost;
    logic             idx_wrap;
    logic [IDX_W-1:0] idx_next;
    logic [SW_W-1:0]  sweep_next;
    logic             go_fail;
    logic             go_reset;
    logic [IDX_W-1:0] reset_idx;
    logic [SW_W-1:0]  reset_sweep;

    assign in_search    = (state_reg == WAIT_LOCK) || (state_reg == CONFIRM);
    assign to_hit       = (timeout_reg == TO_W'(LOCK_TIMEOUT - 1));
    assign confirm_done = (state_reg == CONFIRM) && lock_s &&
                          (stable_reg == ST_W'(LOCK_STABLE - 1));

    // A lock confirmed in the very cycle the budget expires is kept rather
    // than thrown away; retune_req overrides everything.
    assign timeout_evt  = in_search && to_hit && !confirm_done && !retune_req;
    assign lock_lost    = (state_reg == LOCKED) && !lock_s;

    assign idx_wrap     = (idx_reg == IDX_W'(NUM_SETTINGS - 1));
    assign idx_next     = idx_wrap ? '0 : idx_reg + 1'b1;
    assign sweep_next   = idx_wrap ? sweep_reg + 1'b1 : sweep_reg;

    assign go_fail      = timeout_evt && (sweep_next == SW_W'(MAX_SWEEPS));
    assign go_reset     = retune_req || (timeout_evt && !go_fail) || lock_lost;

    // Lock loss keeps the entry that worked but restarts the sweep budget.
    assign reset_idx    = retune_req  ? '0 :
                          timeout_evt ? idx_next : idx_reg;
    assign reset_sweep  = retune_req  ? '0 :
                          timeout_evt ? sweep_next : '0;

    // ------------------------------------------------------------------
    // Supervisor FSM. The loop outputs are written only on the transition
    // into RESET_PLL, so they never move while the PLL is running.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RESET_PLL;
            idx_reg     <= '0;
            sweep_reg   <= '0;
            rst_cnt_reg <= '0;
            timeout_reg <= '0;
            stable_reg  <= '0;
            reset_reg   <= 1'b1;
            setting_reg <= pll_setting_t'(SETTINGS[SETTING_W-1:0]);
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
        end else if (go_reset) begin
            state_reg   <= RESET_PLL;
            idx_reg     <= reset_idx;
            sweep_reg   <= reset_sweep;
            rst_cnt_reg <= '0;
            timeout_reg <= '0;
            stable_reg  <= '0;
            reset_reg   <= 1'b1;
            setting_reg <= setting_tbl[reset_idx];
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
        end else if (go_fail) begin
            // idx stays on the last entry tried so setting_idx keeps
            // matching the loop outputs, which are frozen in FAIL.
            state_reg   <= FAIL;
            sweep_reg   <= sweep_next;
            reset_reg   <= 1'b1;
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b1;
        end else begin
            case (state_reg)
                RESET_PLL: begin
                    if (rst_cnt_reg == RC_W'(RESET_CYCLES - 1)) begin
                        state_reg <= WAIT_LOCK;
                        reset_reg <= 1'b0;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    timeout_reg <= timeout_reg + 1'b1;
                    if (lock_s) begin
                        state_reg  <= CONFIRM;
                        stable_reg <= '0;
                    end
                end
                CONFIRM: begin
                    timeout_reg <= timeout_reg + 1'b1;
                    if (!lock_s) begin
                        state_reg  <= WAIT_LOCK;
                        stable_reg <= '0;
                    end else if (confirm_done) begin
                        state_reg <= LOCKED;
                        ready_reg <= 1'b1;
                    end else begin
                        stable_reg <= stable_reg + 1'b1;
                    end
                end
                LOCKED: begin
                    // Lock loss is handled by the go_reset path above.
                end
                FAIL: begin
                    // Parked until retune_req.
                end
                default: begin
                    state_reg   <= RESET_PLL;
                    rst_cnt_reg <= '0;
                    reset_reg   <= 1'b1;
                    ready_reg   <= 1'b0;
                    fail_reg    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef PLL_TUNER_STATS_EN
    logic [7:0] lock_loss_reg;
    logic [7:0] retry_reg;
    logic       lock_loss_evt;

    assign lock_loss_evt = lock_lost && !retune_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_reg <= '0;
            retry_reg     <= '0;
        end else if (retune_req) begin
            lock_loss_reg <= '0;
            retry_reg     <= '0;
        end else begin
            if (lock_loss_evt && (lock_loss_reg != 8'hFF)) begin
                lock_loss_reg <= lock_loss_reg + 1'b1;
            end
            if (timeout_evt && (retry_reg != 8'hFF)) begin
                retry_reg <= retry_reg + 1'b1;
            end
        end
    end

    assign lock_loss_cnt = lock_loss_reg;
    assign retry_cnt     = retry_reg;
`else
    assign lock_loss_cnt = '0;
    assign retry_cnt     = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign pll_reset   = reset_reg;
    assign pll_icpsel  = setting_reg.icp;
    assign pll_lpfres  = setting_reg.res;
    assign pll_lpfcap  = setting_reg.cap;
    assign pll_ready   = ready_reg;
    assign tune_fail   = fail_reg;
    assign setting_idx = idx_reg;

endmodule
